message_schedule: RTL and testbench
===================================

Name: message_schedule

Overview:
- SHA-256 message schedule expander. Sits directly downstream of the message padding/build stage and consumes its 512-bit padded blocks.
- Expands each 512-bit block into the 64 32-bit schedule words W0..W63 and streams them one per cycle to the compression stage.
- Carries the end-of-message flag through so the compression stage knows when to emit a digest.

Parameters:
- None. Block width (512), word width (32) and round count (64) are fixed by SHA-256.

Ports:
- clk  input  1  system clock; all logic on rising edge
- sync_rst  input  1  reset, synchronous, active-high
- data_in  input  512  padded message block; bits [511:480] = W0, [31:0] = W15 (big-endian word order)
- data_in_last  input  1  block is the final block of a message
- data_in_valid  input  1  upstream block valid
- data_in_ready  output  1  block can be accepted
- data_out  output  32  schedule word W_t
- data_out_index  output  6  t, 0..63
- data_out_block_end  output  1  high when t == 63
- data_out_last  output  1  high when t == 63 and the block carried data_in_last
- data_out_valid  output  1  data_out valid
- data_out_ready  input  1  downstream ready

Behaviour:
- Reset: sync_rst is sampled at the clock edge and has priority over every handshake. Reset values:
  - state = INIT
  - data_in_ready = 0
  - data_out_valid = 0
  - data_out = 0, data_out_index = 0, data_out_block_end = 0, data_out_last = 0
  - shift register and msg_last flag cleared
- A reset mid-block discards the block with no partial flush.
- Outputs and data_in_ready are all registered; no combinational path from any input to any output.
- Storage: 16 x 32-bit shift register w[0..15], where w[0] is the oldest word. One 6-bit counter t. One msg_last flag.
- State machine:
  - INIT: one cycle after reset. Next: IDLE with data_in_ready = 1.
  - IDLE: data_in_ready = 1, data_out_valid = 0. On data_in_valid & data_in_ready:
    - load w[k] = data_in[511-32k -: 32]
    - msg_last = data_in_last, t = 0
    - data_in_ready = 0, data_out_valid = 1; next: RUN
  - RUN: data_out = w[0], data_out_index = t, data_out_block_end = (t == 63), data_out_last = msg_last & (t == 63).
    - On data_out_valid & data_out_ready with t < 63:
      - shift w[i] = w[i+1]
      - w[15] = sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0]
      - t = t + 1
    - On handshake with t == 63: data_out_valid = 0, data_in_ready = 1; next: IDLE.
    - With data_out_valid & !data_out_ready: every output and all internal state hold stable.
- Arithmetic (all additions mod 2^32, carries discarded):
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
- Latency: input handshake in cycle N gives W0 valid in cycle N+1.
- Throughput: 1 word/cycle under continuous ready. One bubble cycle (IDLE) between blocks, i.e. 65 cycles per block.
- data_in_valid is ignored while in RUN. data_in_ready never rises during RUN.
- data_in_last is latched only at acceptance; its value on other cycles is don't-care.
- data_out_index wraps only via the return to IDLE and never exceeds 63.

Test Plan:
- "abc" padded block (0x61626380, 13 zero words, 0x00000000, 0x00000018), last = 1, ready held high:
  - W0 = 0x61626380, W15 = 0x00000018
  - W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405, W19 = 0x600003C6, W63 = 0x12B1EDEB
  - data_out_last and data_out_block_end high only at index 63
  - W0 appears one cycle after acceptance
- All-zero block, last = 0: all 64 words = 0; data_out_block_end = 1 at index 63; data_out_last = 0 throughout.
- "abc" block, data_out_ready low for 3 cycles while index = 5: data_out, data_out_index = 5 and data_out_valid held stable; sequence resumes with W6 = 0; W63 still 0x12B1EDEB.
- Two blocks offered back-to-back with data_in_valid held high (first last = 0, second last = 1):
  - exactly one IDLE cycle between the index-63 handshake and the second block's acceptance
  - data_out_last = 1 only at index 63 of the second block
  - data_in_ready = 0 throughout RUN
- Assert sync_rst for 1 cycle at index 20:
  - next cycle all outputs at reset values
  - one INIT cycle, then data_in_ready = 1
  - a newly offered "abc" block produces the correct full sequence from W0.
- After reset, data_in_valid held high before INIT completes: no acceptance while data_in_ready = 0; accepted on the first IDLE cycle.

Source files
------------

// File: rtl/message_schedule_if.sv
// message_schedule_if: bundles the block-in / word-out handshake of the SHA-256
// message schedule expander.
//   data_in[511:0], data_in_last, data_in_valid  : padded block from upstream
//   data_in_ready                                : expander can accept a block
//   data_out[31:0], data_out_index[5:0]          : schedule word W_t and t
//   data_out_block_end, data_out_last            : t == 63 / t == 63 of final block
//   data_out_valid, data_out_ready               : word handshake to compression
// master = block producer / word consumer, slave = the expander.
interface message_schedule_if;
  localparam int unsigned BLOCK_W = 512;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned IDX_W   = 6;

  logic [BLOCK_W-1:0] data_in;
  logic               data_in_last;
  logic               data_in_valid;
  logic               data_in_ready;
  logic [WORD_W-1:0]  data_out;
  logic [IDX_W-1:0]   data_out_index;
  logic               data_out_block_end;
  logic               data_out_last;
  logic               data_out_valid;
  logic               data_out_ready;

  modport master (
    output data_in, data_in_last, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_index, data_out_block_end,
           data_out_last, data_out_valid
  );

  modport slave (
    input  data_in, data_in_last, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_index, data_out_block_end,
           data_out_last, data_out_valid
  );
endinterface

// File: rtl/message_schedule.sv
// message_schedule: SHA-256 message schedule expander. Accepts one 512-bit
// padded block, then streams W0..W63 one word per handshake, carrying the
// end-of-message flag to the final word of the block.
//   clk       : rising-edge clock
//   sync_rst  : synchronous active-high reset, overrides all handshakes
//   bus       : message_schedule_if.slave (block in, schedule word out)
// All outputs are register-driven.
module message_schedule (
  input  logic              clk,
  input  logic              sync_rst,
  message_schedule_if.slave bus
);
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned N_WORDS = 16;
  localparam int unsigned IDX_W   = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = 6'd63;
  localparam logic [IDX_W-1:0] PENULT_IDX = 6'd62;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]        r_state,     w_state_nxt;
  logic [WORD_W-1:0] r_w [N_WORDS];
  logic [WORD_W-1:0] w_w_nxt [N_WORDS];
  logic [IDX_W-1:0]  r_t,         w_t_nxt;
  logic              r_msg_last,  w_msg_last_nxt;
  logic              r_in_ready,  w_in_ready_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_block_end, w_block_end_nxt;
  logic              r_out_last,  w_out_last_nxt;
  logic [WORD_W-1:0] w_new_word;

  function automatic logic [WORD_W-1:0] f_sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] f_sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // w[0] holds W_t, so w[14], w[9], w[1], w[0] are W_(t+14), W_(t+9), W_(t+1), W_t
  assign w_new_word = f_sigma1(r_w[14]) + r_w[9] + f_sigma0(r_w[1]) + r_w[0];

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    for (int unsigned k = 0; k < N_WORDS; k++) w_w_nxt[k] = r_w[k];
    w_t_nxt         = r_t;
    w_msg_last_nxt  = r_msg_last;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_block_end_nxt = r_block_end;
    w_out_last_nxt  = r_out_last;

    case (r_state)
      ST_INIT: begin
        w_state_nxt    = ST_IDLE;
        w_in_ready_nxt = 1'b1;
      end
      ST_IDLE: begin
        if (bus.data_in_valid && r_in_ready) begin
          // Big-endian word order: W0 sits in the top 32 bits
          for (int unsigned k = 0; k < N_WORDS; k++)
            w_w_nxt[k] = bus.data_in[WORD_W*(N_WORDS-1-k) +: WORD_W];
          w_msg_last_nxt  = bus.data_in_last;
          w_t_nxt         = '0;
          w_in_ready_nxt  = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_block_end_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          w_state_nxt     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_out_valid && bus.data_out_ready) begin
          if (r_t == LAST_IDX) begin
            w_out_valid_nxt = 1'b0;
            w_in_ready_nxt  = 1'b1;
            w_state_nxt     = ST_IDLE;
          end else begin
            for (int unsigned k = 0; k < N_WORDS - 1; k++) w_w_nxt[k] = r_w[k+1];
            w_w_nxt[N_WORDS-1] = w_new_word;
            w_t_nxt            = r_t + 6'd1;
            // Flags are precomputed so they are registered alongside the word
            w_block_end_nxt    = (r_t == PENULT_IDX);
            w_out_last_nxt     = r_msg_last && (r_t == PENULT_IDX);
          end
        end
      end
      default: begin
        w_state_nxt    = ST_INIT;
        w_in_ready_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_state     <= ST_INIT;
      for (int unsigned k = 0; k < N_WORDS; k++) r_w[k] <= '0;
      r_t         <= '0;
      r_msg_last  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_block_end <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      for (int unsigned k = 0; k < N_WORDS; k++) r_w[k] <= w_w_nxt[k];
      r_t         <= w_t_nxt;
      r_msg_last  <= w_msg_last_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_block_end <= w_block_end_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign bus.data_in_ready      = r_in_ready;
  assign bus.data_out           = r_w[0];
  assign bus.data_out_index     = r_t;
  assign bus.data_out_block_end = r_block_end;
  assign bus.data_out_last      = r_out_last;
  assign bus.data_out_valid     = r_out_valid;
endmodule

// File: tb/tb_message_schedule.sv
// tb_message_schedule: directed bench for the SHA-256 message schedule
// expander, with a reference schedule model and a table of known words.
module tb_message_schedule;
  logic clk = 1'b0;
  logic sync_rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  message_schedule_if bus();

  message_schedule dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .bus      (bus)
  );

  localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] ZERO = 512'h0;

  typedef struct {
    logic [511:0] blk;
    logic         lst;
    int           idx;
    logic [31:0]  w;
    logic         bend;
    logic         last;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] got_w    [64];
  logic        got_end  [64];
  logic        got_last [64];
  int          got_cyc  [64];
  logic [31:0] ref_w    [64];
  int          acc_cyc;
  logic        ready_in_run;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook schedule recurrence, indexed by absolute t
  task automatic build_ref(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) ref_w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3);
      s1 = rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10);
      ref_w[t] = s1 + ref_w[t-7] + s0 + ref_w[t-16];
    end
  endtask

  // Offer a block (from a negedge) and collect its 64 words.
  // stall_at/stall_n: drop data_out_ready for stall_n cycles at that index.
  // rst_at: pulse sync_rst when that index is presented, then return.
  // hold: keep data_in_valid high and present nblk/nlst for the next block.
  task automatic stream(input logic [511:0] blk, input logic lst, input logic hold,
                        input logic [511:0] nblk, input logic nlst,
                        input int stall_at, input int stall_n, input int rst_at,
                        output logic aborted);
    int          guard;
    int          idx;
    logic        done;
    logic [31:0] snap;
    for (int i = 0; i < 64; i++) begin
      got_w[i] = 'x; got_end[i] = 1'bx; got_last[i] = 1'bx; got_cyc[i] = -1;
    end
    aborted = 1'b0;
    ready_in_run = 1'b0;
    bus.data_in = blk;
    bus.data_in_last = lst;
    bus.data_in_valid = 1'b1;
    bus.data_out_ready = 1'b1;
    guard = 0;
    while (bus.data_in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (bus.data_in_ready !== 1'b1) begin
      chk("accept_timeout", 32'(bus.data_in_ready), 32'd1);
      bus.data_in_valid = 1'b0;
      aborted = 1'b1;
      return;
    end
    acc_cyc = cyc;
    @(negedge clk);
    if (hold) begin
      bus.data_in = nblk;
      bus.data_in_last = nlst;
    end else begin
      bus.data_in_valid = 1'b0;
    end
    done = 1'b0;
    guard = 0;
    while (!done && guard < 200) begin
      if (bus.data_in_ready !== 1'b0) ready_in_run = 1'b1;
      if (bus.data_out_valid === 1'b1) begin
        idx = int'(bus.data_out_index);
        if (rst_at >= 0 && idx == rst_at) begin
          sync_rst = 1'b1;
          @(negedge clk);
          sync_rst = 1'b0;
          aborted = 1'b1;
          return;
        end
        if (idx == stall_at && stall_n > 0) begin
          snap = bus.data_out;
          bus.data_out_ready = 1'b0;
          for (int s = 0; s < stall_n; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.data_out_valid), 32'd1);
            chk("stall_index", 32'(bus.data_out_index), 32'(stall_at));
            chk("stall_word", bus.data_out, snap);
          end
          bus.data_out_ready = 1'b1;
          stall_n = 0;
        end
        got_w[idx]    = bus.data_out;
        got_end[idx]  = bus.data_out_block_end;
        got_last[idx] = bus.data_out_last;
        got_cyc[idx]  = cyc;
        if (idx == 63) done = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    if (!done) chk("stream_timeout", 32'(done), 32'd1);
  endtask

  // Compare every captured word and flag against the reference model
  task automatic sweep(input logic [511:0] blk, input logic lst, input string tag);
    build_ref(blk);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("%s_w%0d", tag, i), got_w[i], ref_w[i]);
      chk($sformatf("%s_end%0d", tag, i), 32'(got_end[i]), 32'(i == 63));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(lst && (i == 63)));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.data_in_ready), 32'd0);
    chk({tag, "_valid"}, 32'(bus.data_out_valid), 32'd0);
    chk({tag, "_data"}, bus.data_out, 32'd0);
    chk({tag, "_index"}, 32'(bus.data_out_index), 32'd0);
    chk({tag, "_block_end"}, 32'(bus.data_out_block_end), 32'd0);
    chk({tag, "_last"}, 32'(bus.data_out_last), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl [12];
    logic [511:0] cur_blk;
    logic         cur_lst;
    logic [511:0] b2;
    logic         ab;
    int           c0;
    int           e1;

    tbl[0]  = '{ABC,  1'b1, 0,  32'h61626380, 1'b0, 1'b0};
    tbl[1]  = '{ABC,  1'b1, 15, 32'h00000018, 1'b0, 1'b0};
    tbl[2]  = '{ABC,  1'b1, 16, 32'h61626380, 1'b0, 1'b0};
    tbl[3]  = '{ABC,  1'b1, 17, 32'h000F0000, 1'b0, 1'b0};
    tbl[4]  = '{ABC,  1'b1, 18, 32'h7DA86405, 1'b0, 1'b0};
    tbl[5]  = '{ABC,  1'b1, 19, 32'h600003C6, 1'b0, 1'b0};
    tbl[6]  = '{ABC,  1'b1, 62, 32'h0, 1'b0, 1'b0}; // word checked by sweep
    tbl[7]  = '{ABC,  1'b1, 63, 32'h12B1EDEB, 1'b1, 1'b1};
    tbl[8]  = '{ZERO, 1'b0, 0,  32'h0, 1'b0, 1'b0};
    tbl[9]  = '{ZERO, 1'b0, 31, 32'h0, 1'b0, 1'b0};
    tbl[10] = '{ZERO, 1'b0, 62, 32'h0, 1'b0, 1'b0};
    tbl[11] = '{ZERO, 1'b0, 63, 32'h0, 1'b1, 1'b0};

    for (int k = 0; k < 16; k++) b2[511 - 32*k -: 32] = 32'(k + 1) * 32'h01010101;

    // Reset with a block already offered: no acceptance before the IDLE cycle
    sync_rst = 1'b1;
    bus.data_in = ABC;
    bus.data_in_last = 1'b1;
    bus.data_in_valid = 1'b1;
    bus.data_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    sync_rst = 1'b0;
    c0 = cyc;
    stream(ABC, 1'b1, 1'b0, ZERO, 1'b0, -1, 0, -1, ab);
    chk("first_accept_cycle", 32'(acc_cyc), 32'(c0 + 1));
    chk("w0_latency", 32'(got_cyc[0]), 32'(acc_cyc + 1));
    chk("full_rate", 32'(got_cyc[63] - got_cyc[0]), 32'd63);
    chk("abc_in_ready_run", 32'(ready_in_run), 32'd0);
    sweep(ABC, 1'b1, "abc");
    cur_blk = ABC;
    cur_lst = 1'b1;

    // Table of known words; re-stream only when the block changes
    for (int v = 0; v < 12; v++) begin
      if (tbl[v].blk !== cur_blk || tbl[v].lst !== cur_lst) begin
        stream(tbl[v].blk, tbl[v].lst, 1'b0, ZERO, 1'b0, -1, 0, -1, ab);
        sweep(tbl[v].blk, tbl[v].lst, "tblblk");
        cur_blk = tbl[v].blk;
        cur_lst = tbl[v].lst;
      end
      if (v != 6) chk($sformatf("tbl%0d_word", v), got_w[tbl[v].idx], tbl[v].w);
      chk($sformatf("tbl%0d_end", v), 32'(got_end[tbl[v].idx]), 32'(tbl[v].bend));
      chk($sformatf("tbl%0d_last", v), 32'(got_last[tbl[v].idx]), 32'(tbl[v].last));
    end

    // Downstream stall at index 5
    stream(ABC, 1'b1, 1'b0, ZERO, 1'b0, 5, 3, -1, ab);
    chk("stall_w6", got_w[6], 32'h0);
    chk("stall_w63", got_w[63], 32'h12B1EDEB);
    sweep(ABC, 1'b1, "stall");

    // Back-to-back blocks with data_in_valid held high
    stream(ABC, 1'b0, 1'b1, b2, 1'b1, -1, 0, -1, ab);
    e1 = got_cyc[63];
    chk("b2b_first_ready_run", 32'(ready_in_run), 32'd0);
    sweep(ABC, 1'b0, "b2b_first");
    stream(b2, 1'b1, 1'b0, ZERO, 1'b0, -1, 0, -1, ab);
    chk("b2b_one_bubble", 32'(acc_cyc), 32'(e1 + 1));
    chk("b2b_second_ready_run", 32'(ready_in_run), 32'd0);
    sweep(b2, 1'b1, "b2b_second");

    // Reset in the middle of a block
    stream(ABC, 1'b1, 1'b0, ZERO, 1'b0, -1, 0, 20, ab);
    chk("midrst_aborted", 32'(ab), 32'd1);
    chk_reset_outputs("midrst");
    @(negedge clk);
    chk("midrst_ready_after_init", 32'(bus.data_in_ready), 32'd1);
    chk("midrst_valid_after_init", 32'(bus.data_out_valid), 32'd0);
    stream(ABC, 1'b1, 1'b0, ZERO, 1'b0, -1, 0, -1, ab);
    chk("midrst_w63", got_w[63], 32'h12B1EDEB);
    sweep(ABC, 1'b1, "midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
